// File: rtl/btb_pkg.sv
// Branch target buffer shared types: FSM state, counter defaults,
// saturating counter helper and the reference entry layout.
package btb_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        INV  = 2'd2
    } btb_state_e;

    localparam logic [1:0] CTR_INIT_DEF = 2'b10;

    localparam int BTB_PC_W  = 16;
    localparam int BTB_DEPTH = 1024;
    localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
    localparam int BTB_TAG_W = BTB_PC_W - 1 - BTB_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-2:0]  target;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] n;
        n = ctr;
        if (taken && ctr != 2'b11) begin
            n = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            n = ctr - 2'b01;
        end
        return n;
    endfunction

endpackage

// File: rtl/btb_ctr_sat.sv
// 2-bit saturating direction counter next-state logic.
// Ports: ctr_i current count, taken_i outcome, ctr_o next count.
module btb_ctr_sat
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    assign ctr_o = ctr_next(ctr_i, taken_i);

endmodule

// File: rtl/btb_predictor.sv
// Tagged branch target buffer with 2-bit counters and a sequenced
// valid-bit sweep (INIT after reset, INV on inv_req).
// Ports: lookup_pc -> pred_hit/pred_taken/pred_target (combinational),
// upd_* training from writeback, inv_req, ready, perf_* counters.
// Define BTB_PERF_EN to build the saturating performance counters;
// otherwise perf_* are tied to 0.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int         PC_W     = 16,
    parameter int         DEPTH    = 1024,
    parameter int         IDX_W    = $clog2(DEPTH),
    parameter int         TAG_W    = PC_W - 1 - IDX_W,
    parameter logic [1:0] CTR_INIT = CTR_INIT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            inv_req,
    output logic            ready,
    output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_hits,
    output logic [31:0]     perf_allocs
);

    localparam int TGT_W = PC_W - 1;
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] tgt;
        logic [1:0]       ctr;
    } ent_t;

    btb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;

    logic [DEPTH-1:0] valid_q;
    ent_t             ent_q [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    ent_t             lk_e;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    ent_t             up_e;
    logic             up_hit;
    logic             up_en;
    logic             alloc;
    logic             train;
    logic [1:0]       ctr_nxt;

    logic             unused_bits;

    assign ready = (state_q == RUN);

    assign lk_idx = lookup_pc[IDX_W:1];
    assign lk_tag = lookup_pc[PC_W-1:IDX_W+1];
    assign lk_e   = ent_q[lk_idx];

    // ready gates the hit so unswept entries never predict
    assign pred_hit    = ready & valid_q[lk_idx]
                         & (lk_e.tag == lk_tag);
    assign pred_taken  = pred_hit & lk_e.ctr[1];
    assign pred_target = pred_taken ? {lk_e.tgt, 1'b0}
                                    : lookup_pc + PC_W'(2);

    assign up_idx = upd_pc[IDX_W:1];
    assign up_tag = upd_pc[PC_W-1:IDX_W+1];
    assign up_e   = ent_q[up_idx];
    assign up_hit = valid_q[up_idx] & (up_e.tag == up_tag);
    assign up_en  = upd_valid & ready;
    assign alloc  = up_en & ~up_hit & upd_taken;
    assign train  = up_en & up_hit;

    assign unused_bits = ^{upd_pc[0], upd_target[0]};

    btb_ctr_sat u_ctr (
        .ctr_i   (up_e.ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (inv_req) begin
                        state_q <= INV;
                        ptr_q   <= '0;
                    end
                end
                INIT, INV: begin
                    if (inv_req) begin
                        ptr_q <= '0;
                    end else if (ptr_q == PTR_LAST) begin
                        state_q <= RUN;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Entry storage is deliberately unreset; the sweep clears valid bits.
    always_ff @(posedge clk) begin
        if (!ready) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (alloc) begin
            valid_q[up_idx] <= 1'b1;
            ent_q[up_idx]   <= '{tag: up_tag,
                                 tgt: upd_target[PC_W-1:1],
                                 ctr: CTR_INIT};
        end else if (train) begin
            ent_q[up_idx].ctr <= ctr_nxt;
            if (upd_taken) begin
                ent_q[up_idx].tgt <= upd_target[PC_W-1:1];
            end
        end
    end

`ifdef BTB_PERF_EN
    logic [31:0] lk_cnt_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] al_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_cnt_q  <= '0;
            hit_cnt_q <= '0;
            al_cnt_q  <= '0;
        end else begin
            if (ready && lk_cnt_q != '1) begin
                lk_cnt_q <= lk_cnt_q + 32'd1;
            end
            if (pred_hit && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (alloc && al_cnt_q != '1) begin
                al_cnt_q <= al_cnt_q + 32'd1;
            end
        end
    end

    assign perf_lookups = lk_cnt_q;
    assign perf_hits    = hit_cnt_q;
    assign perf_allocs  = al_cnt_q;
`else
    assign perf_lookups = '0;
    assign perf_hits    = '0;
    assign perf_allocs  = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor built with DEPTH=16
// (idx = pc[4:1], tag = pc[15:5]).
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        inv_req;
    logic        ready;
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;
    logic [31:0] perf_allocs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btb_predictor #(
        .PC_W  (16),
        .DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .inv_req      (inv_req),
        .ready        (ready),
        .perf_lookups (perf_lookups),
        .perf_hits    (perf_hits),
        .perf_allocs  (perf_allocs)
    );

    task automatic do_upd(input logic [15:0] pc, input logic tk,
                          input logic [15:0] tgt);
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_valid  = 1'b1;
        @(posedge clk);
        #1;
        upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n      = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        inv_req    = 1'b0;
        look(16'h0040);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready got %b exp 0", ready);
        end
        n_checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hit got %b/%b exp 0/0",
                     pred_hit, pred_taken);
        end
        n_checks++;
        if (pred_target !== 16'h0042) begin
            n_fail++;
            $display("FAIL rst_target got %h exp 0042", pred_target);
        end
        n_checks++;
        if ({perf_lookups, perf_hits, perf_allocs} !== 96'd0) begin
            n_fail++;
            $display("FAIL rst_perf got %h %h %h exp 0",
                     perf_lookups, perf_hits, perf_allocs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL init_len got %0d exp 16", n);
        end
        look(16'h0040);
        n_checks++;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0042) begin
            n_fail++;
            $display("FAIL post_init got %b %h exp 0 0042",
                     pred_hit, pred_target);
        end
    endtask

    task automatic test_alloc;
        do_upd(16'h0010, 1'b1, 16'h0200);
        look(16'h0010);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 16'h0200}) begin
            n_fail++;
            $display("FAIL alloc got %b%b %h exp 11 0200",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias;
        do_upd(16'h0030, 1'b1, 16'h0400);
        look(16'h0010);
        n_checks++;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0012) begin
            n_fail++;
            $display("FAIL alias_old got %b %h exp 0 0012",
                     pred_hit, pred_target);
        end
        look(16'h0030);
        n_checks++;
        if (pred_hit !== 1'b1 || pred_target !== 16'h0400) begin
            n_fail++;
            $display("FAIL alias_new got %b %h exp 1 0400",
                     pred_hit, pred_target);
        end
        do_upd(16'h0040, 1'b0, 16'h0800);
        look(16'h0040);
        n_checks++;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0042) begin
            n_fail++;
            $display("FAIL miss_nt got %b %h exp 0 0042",
                     pred_hit, pred_target);
        end
    endtask

    task automatic test_hysteresis;
        do_upd(16'h0020, 1'b1, 16'h0100);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 16'h0100}) begin
            n_fail++;
            $display("FAIL hy_alloc got %b%b %h exp 11 0100",
                     pred_hit, pred_taken, pred_target);
        end
        do_upd(16'h0020, 1'b0, 16'h0000);
        do_upd(16'h0020, 1'b0, 16'h0000);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b10, 16'h0022}) begin
            n_fail++;
            $display("FAIL hy_ctr0 got %b%b %h exp 10 0022",
                     pred_hit, pred_taken, pred_target);
        end
        do_upd(16'h0020, 1'b0, 16'h0000);
        do_upd(16'h0020, 1'b1, 16'h0100);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken} !== 2'b10) begin
            n_fail++;
            $display("FAIL hy_ctr1 got %b%b exp 10",
                     pred_hit, pred_taken);
        end
        do_upd(16'h0020, 1'b1, 16'h0180);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 16'h0180}) begin
            n_fail++;
            $display("FAIL hy_ctr2 got %b%b %h exp 11 0180",
                     pred_hit, pred_taken, pred_target);
        end
        for (int i = 0; i < 3; i++) begin
            do_upd(16'h0020, 1'b1, 16'h0180);
        end
        do_upd(16'h0020, 1'b0, 16'h0000);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 16'h0180}) begin
            n_fail++;
            $display("FAIL hy_sat3 got %b%b %h exp 11 0180",
                     pred_hit, pred_taken, pred_target);
        end
        do_upd(16'h0020, 1'b0, 16'h0000);
        look(16'h0020);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b10, 16'h0022}) begin
            n_fail++;
            $display("FAIL hy_down got %b%b %h exp 10 0022",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_conflict;
        lookup_pc  = 16'h0010;
        upd_pc     = 16'h0010;
        upd_taken  = 1'b1;
        upd_target = 16'h0300;
        upd_valid  = 1'b1;
        #1;
        n_checks++;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0012) begin
            n_fail++;
            $display("FAIL conf_miss_old got %b %h exp 0 0012",
                     pred_hit, pred_target);
        end
        @(posedge clk);
        #1;
        upd_target = 16'h0340;
        #1;
        n_checks++;
        if (pred_hit !== 1'b1 || pred_target !== 16'h0300) begin
            n_fail++;
            $display("FAIL conf_hit_old got %b %h exp 1 0300",
                     pred_hit, pred_target);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (pred_hit !== 1'b1 || pred_target !== 16'h0340) begin
            n_fail++;
            $display("FAIL conf_new got %b %h exp 1 0340",
                     pred_hit, pred_target);
        end
    endtask

    task automatic test_inv;
        logic [15:0] pcs [5];
        int n;
        pcs = '{16'h0010, 16'h0020, 16'h0030, 16'h0050, 16'h0060};
        lookup_pc  = 16'h0060;
        upd_pc     = 16'h0060;
        upd_taken  = 1'b1;
        upd_target = 16'h0500;
        upd_valid  = 1'b1;
        inv_req    = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        inv_req   = 1'b0;
        look(16'h0010);
        n_checks++;
        if (ready !== 1'b0 || pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_enter got %b %b exp 0 0",
                     ready, pred_hit);
        end
        do_upd(16'h0050, 1'b1, 16'h0600);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || pred_target !== 16'h0012) begin
            n_fail++;
            $display("FAIL inv_rst got %b %h exp 0 0012",
                     ready, pred_target);
        end
        rst_n = 1'b1;
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL rst_sweep_len got %0d exp 16", n);
        end
        foreach (pcs[i]) begin
            look(pcs[i]);
            n_checks++;
            if (pred_hit !== 1'b0 || pred_target !== pcs[i] + 16'd2) begin
                n_fail++;
                $display("FAIL swept_%h got %b %h exp 0 %h", pcs[i],
                         pred_hit, pred_target, pcs[i] + 16'd2);
            end
        end
    endtask

    task automatic test_inv_restart;
        int n;
        do_upd(16'h0010, 1'b1, 16'h0200);
        inv_req = 1'b1;
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
        end
        #1;
        inv_req = 1'b1;
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL restart_len got %0d exp 16", n);
        end
        look(16'h0010);
        n_checks++;
        if (pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_miss got %b exp 0", pred_hit);
        end
        do_upd(16'h0010, 1'b1, 16'h0220);
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 16'h0220}) begin
            n_fail++;
            $display("FAIL realloc got %b%b %h exp 11 0220",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    initial begin
        test_reset;
        test_alloc;
        test_alias;
        test_hysteresis;
        test_conflict;
        test_inv;
        test_inv_restart;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
